// File: rtl/mem_op_engine_pkg.sv
// Shared types and default sizes for the memory-operand logic/arith engine.
package mem_op_engine_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 3;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    EXEC,
    WB
  } state_e;

endpackage

// File: rtl/mem_op_engine_if.sv
// Host-side bundle for mem_op_engine: operation request, host write/read port and status.
interface mem_op_engine_if
  import mem_op_engine_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
);

  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [AW-1:0] c_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          carry;
  logic          err;

  modport master (
    output start, op, a_addr, b_addr, c_addr, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, done, result, carry, err
  );

  modport slave (
    input  start, op, a_addr, b_addr, c_addr, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy, done, result, carry, err
  );

endinterface

// File: rtl/mem_op_regfile.sv
// 2^AW x DW register file: one write port, one engine read port, one host read port.
module mem_op_regfile
  import mem_op_engine_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] host_raddr,
  output logic [DW-1:0] host_rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Reset clears every word and wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata      = mem[raddr];
  assign host_rdata = mem[host_raddr];

endmodule

// File: rtl/mem_op_engine.sv
// Two-operand memory engine: reads mem[a], mem[b], applies AND/OR/XOR(/ADD), writes mem[c].
// ADD is available only when MEM_OP_ENGINE_ARITH_EN is defined; otherwise op=11 is rejected with err.
module mem_op_engine
  import mem_op_engine_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  mem_op_engine_if.slave   bus
);

  state_e        state_q, state_d;
  op_e           op_q;
  logic [AW-1:0] a_q, b_q, c_q;

  logic [DW-1:0] opa_p1, opb_p2, res_p3;
  logic          carry_p3, err_p3;

  logic [DW-1:0] result_q;
  logic          carry_q, done_q, err_q;

  logic          rf_we;
  logic [AW-1:0] rf_waddr, rf_raddr;
  logic [DW-1:0] rf_wdata, rf_rdata;

  // Packs {err, carry, value}.
  function automatic logic [DW+1:0] alu(input op_e op, input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MEM_OP_ENGINE_ARITH_EN
    logic [DW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
`endif
    case (op)
      OP_AND:  return {2'b00, a & b};
      OP_OR:   return {2'b00, a | b};
      OP_XOR:  return {2'b00, a ^ b};
`ifdef MEM_OP_ENGINE_ARITH_EN
      default: return {1'b0, sum};
`else
      default: return {2'b10, {DW{1'b0}}};
`endif
    endcase
  endfunction

  mem_op_regfile #(.DW(DW), .AW(AW)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we         (rf_we),
    .waddr      (rf_waddr),
    .wdata      (rf_wdata),
    .raddr      (rf_raddr),
    .rdata      (rf_rdata),
    .host_raddr (bus.rd_addr),
    .host_rdata (bus.rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Host writes share the single write port with writeback; they only get it in IDLE.
  always_comb begin
    state_d  = state_q;
    rf_we    = 1'b0;
    rf_waddr = bus.wr_addr;
    rf_wdata = bus.wr_data;
    rf_raddr = a_q;
    case (state_q)
      IDLE: begin
        rf_we = bus.wr_en;
        if (bus.start) state_d = RD_A;
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        rf_raddr = b_q;
        state_d  = EXEC;
      end
      EXEC: state_d = WB;
      WB: begin
        rf_we    = ~err_p3;
        rf_waddr = c_q;
        rf_wdata = res_p3;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // p0: request capture
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start) begin
      op_q <= op_e'(bus.op);
      a_q  <= bus.a_addr;
      b_q  <= bus.b_addr;
      c_q  <= bus.c_addr;
    end
    // p1/p2: operand reads through the shared read port
    if (state_q == RD_A) opa_p1 <= rf_rdata;
    if (state_q == RD_B) opb_p2 <= rf_rdata;
    // p3: execute
    if (state_q == EXEC) {err_p3, carry_p3, res_p3} <= alu(op_q, opa_p1, opb_p2);
  end

  // Status/result registers, updated at the end of WB. A rejected op keeps the old result.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= (state_q == WB);
      err_q  <= (state_q == WB) && err_p3;
      if (state_q == WB) begin
        carry_q <= carry_p3;
        if (!err_p3) result_q <= res_p3;
      end
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_mem_op_engine.sv
// Directed bench for mem_op_engine with a queue scoreboard of expected op results.
module tb_mem_op_engine;
  import mem_op_engine_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_op_engine_if #(.DW(DW), .AW(AW)) bus ();

  mem_op_engine #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic          carry;
    logic          err;
    int            c;
    logic [DW-1:0] memc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] last_res;
  int            checks   = 0;
  int            failures = 0;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    last_res = '0;
  endtask

  task automatic host_write(input int a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic read_check(input string tag, input int a, input logic [DW-1:0] exp);
    bus.rd_addr = AW'(a);
    #1;
    check(tag, bus.rd_data, exp);
  endtask

  task automatic push_expected(input logic [1:0] o, input int a, input int b, input int c);
    exp_t e;
`ifdef MEM_OP_ENGINE_ARITH_EN
    logic [DW:0] s;
`endif
    e.carry = 1'b0;
    e.err   = 1'b0;
    e.c     = c;
    case (o)
      2'b00:   e.res = model_mem[a] & model_mem[b];
      2'b01:   e.res = model_mem[a] | model_mem[b];
      2'b10:   e.res = model_mem[a] ^ model_mem[b];
      default: begin
`ifdef MEM_OP_ENGINE_ARITH_EN
        s       = {1'b0, model_mem[a]} + {1'b0, model_mem[b]};
        e.res   = s[DW-1:0];
        e.carry = s[DW];
`else
        e.err = 1'b1;
        e.res = last_res;
`endif
      end
    endcase
    if (!e.err) begin
      model_mem[c] = e.res;
      last_res     = e.res;
    end
    e.memc = model_mem[c];
    sb.push_back(e);
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=done expected=no_pending_op", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, bus.result, e.res);
      check({tag, "_carry"}, DW'(bus.carry), DW'(e.carry));
      check({tag, "_err"}, DW'(bus.err), DW'(e.err));
      read_check({tag, "_memc"}, e.c, e.memc);
    end
  endtask

  // One full operation; optionally a host write in the start cycle (to b) or during busy (to a).
  task automatic do_op(input string tag, input logic [1:0] o, input int a, input int b, input int c,
                       input bit wr_same, input logic [DW-1:0] wd, input bit wr_busy);
    int n;
    if (wr_same) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(b);
      bus.wr_data = wd;
      model_mem[b] = wd;
    end
    bus.start  = 1'b1;
    bus.op     = o;
    bus.a_addr = AW'(a);
    bus.b_addr = AW'(b);
    bus.c_addr = AW'(c);
    push_expected(o, a, b, c);
    step();
    bus.start  = 1'b0;
    bus.wr_en  = 1'b0;
    bus.op     = 2'($urandom);
    bus.a_addr = 3'($urandom);
    bus.b_addr = 3'($urandom);
    bus.c_addr = 3'($urandom);
    if (wr_busy) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = ~model_mem[a];
    end
    check({tag, "_busy"}, DW'(bus.busy), 1);
    n = 1;
    while (!bus.done && n < 12) begin
      step();
      n++;
    end
    bus.wr_en = 1'b0;
    check({tag, "_latency"}, DW'(n), 5);
    compare_pop(tag);
    step();
    check({tag, "_done_pulse"}, DW'(bus.done), 0);
  endtask

  initial begin
    int dn;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.a_addr  = '0;
    bus.b_addr  = '0;
    bus.c_addr  = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    model_reset();

    rst = 1'b1;
    step();
    step();
    check("rst_busy", DW'(bus.busy), 0);
    check("rst_done", DW'(bus.done), 0);
    check("rst_result", bus.result, 0);
    check("rst_carry", DW'(bus.carry), 0);
    check("rst_err", DW'(bus.err), 0);
    for (int i = 0; i < DEPTH; i++) read_check("rst_mem", i, 0);
    rst = 1'b0;
    step();

    host_write(1, 32'hF0F0_00FF);
    host_write(2, 32'h0FF0_FF0F);
    read_check("wr_mem1", 1, 32'hF0F0_00FF);

    do_op("and", 2'b00, 1, 2, 3, 0, '0, 0);
    check("and_const", bus.result, 32'h00F0_000F);
    read_check("and_mem3", 3, 32'h00F0_000F);
    do_op("or", 2'b01, 1, 2, 0, 0, '0, 0);
    do_op("xor", 2'b10, 1, 2, 7, 0, '0, 0);
    do_op("alias_abc", 2'b10, 3, 3, 3, 0, '0, 0);
    read_check("alias_abc_zero", 3, 0);
    do_op("alias_ca", 2'b01, 1, 2, 1, 0, '0, 0);

    host_write(4, 32'hFFFF_FFFF);
    host_write(5, 32'h0000_0001);
    do_op("add", 2'b11, 4, 5, 6, 0, '0, 0);
    read_check("add_mem6", 6, 0);
`ifdef MEM_OP_ENGINE_ARITH_EN
    check("add_result", bus.result, 0);
    check("add_carry", DW'(bus.carry), 1);
`else
    check("add_carry", DW'(bus.carry), 0);
`endif

    do_op("wr_busy", 2'b00, 1, 2, 4, 0, '0, 1);
    read_check("wr_busy_mem1", 1, model_mem[1]);
    do_op("wr_start", 2'b10, 1, 2, 5, 1, 32'h1234_5678, 0);
    read_check("wr_start_mem2", 2, 32'h1234_5678);

    // Back-to-back: start held high, accepted at k, k+5, k+10.
    bus.start  = 1'b1;
    bus.op     = 2'b10;
    bus.a_addr = 3'd3;
    bus.b_addr = 3'd1;
    bus.c_addr = 3'd3;
    for (int j = 0; j < 3; j++) push_expected(2'b10, 3, 1, 3);
    dn = 0;
    for (int t = 1; t <= 18; t++) begin
      step();
      if (t == 11) bus.start = 1'b0;
      if (bus.done) begin
        dn++;
        check("b2b_time", DW'(t), DW'(dn * 5));
        compare_pop("b2b");
      end
    end
    check("b2b_count", DW'(dn), 3);

    // Reset during EXEC aborts the op.
    bus.start  = 1'b1;
    bus.op     = 2'b01;
    bus.a_addr = 3'd1;
    bus.b_addr = 3'd2;
    bus.c_addr = 3'd6;
    step();
    bus.start = 1'b0;
    step();
    step();
    check("abort_busy_exec", DW'(bus.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", DW'(bus.busy), 0);
    check("abort_done0", DW'(bus.done), 0);
    step();
    check("abort_done1", DW'(bus.done), 0);
    step();
    check("abort_done2", DW'(bus.done), 0);
    check("abort_result", bus.result, 0);
    for (int i = 0; i < DEPTH; i++) read_check("abort_mem", i, 0);
    model_reset();

    // Reset beats start and wr_en in the same cycle.
    host_write(2, 32'hAAAA_AAAA);
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd2;
    bus.wr_data = 32'h5555_5555;
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check("rstprio_busy", DW'(bus.busy), 0);
    read_check("rstprio_mem2", 2, 0);
    model_reset();

    host_write(1, 32'h0000_00F3);
    host_write(2, 32'h0000_0F05);
    do_op("post_rst", 2'b01, 1, 2, 0, 0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_op_engine.md
MEM_OP_ENGINE -- requirements
Module: mem_op_engine

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data word width in bits (DW >= 8).
REQ-002 SHALL have parameter AW, default 3, meaning address width; storage depth is 2^AW words.
REQ-003 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1, operation request, sampled only in IDLE.
REQ-006 SHALL have port op, input, 2, operation select: 00 AND, 01 OR, 10 XOR, 11 ADD.
REQ-007 SHALL have ports a_addr, b_addr, c_addr, input, AW each: operand A, operand B and destination addresses.
REQ-008 SHALL have ports wr_en (input, 1), wr_addr (input, AW), wr_data (input, DW): host write port.
REQ-009 SHALL have ports rd_addr (input, AW) and rd_data (output, DW): host combinational read port.
REQ-010 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port result, output, DW, last computed value, held until the next done.
REQ-013 SHALL have port carry, output, 1, ADD carry-out, held with result.
REQ-014 SHALL have port err, output, 1, asserted with done when an op was rejected.

Function
REQ-015 SHALL implement FSM states IDLE, RD_A, RD_B, EXEC, WB, advancing one state per cycle; WB returns to IDLE.
REQ-016 SHALL accept start=1 in IDLE at edge k, latching op, a_addr, b_addr and c_addr; later changes to these inputs SHALL NOT affect the operation in flight.
REQ-017 SHALL capture mem[a] at the end of RD_A and mem[b] at the end of RD_B through a single internal read port.
REQ-018 SHALL compute the result in EXEC; ADD SHALL wrap modulo 2^DW, with carry equal to bit DW of the sum; carry SHALL be 0 for logic ops.
REQ-019 SHALL write the result to mem[c] at the end of WB, then assert done for exactly one cycle at cycle k+5, with result, carry and err valid.
REQ-020 SHALL hold busy=1 for cycles k+1 through k+4; start while busy SHALL be ignored.
REQ-021 SHALL accept a new start in the same cycle that done is high (back-to-back, 5-cycle throughput).
REQ-022 SHALL perform a host write only when in IDLE; wr_en while busy SHALL be dropped silently.
REQ-023 SHALL, when wr_en and start occur in the same IDLE cycle, perform the write first, so that RD_A/RD_B see the new data.
REQ-024 SHALL handle address aliasing (a=b, c=a or c=b) with reads returning pre-writeback values.

Reset
REQ-025 SHALL, on rst, enter IDLE and clear all storage words, result, carry, done and err to 0, including mid-operation; no writeback SHALL occur for the aborted operation.
REQ-026 SHALL give rst priority over start and wr_en in the same cycle.

Configuration
REQ-027 SHALL use macro MEM_OP_ENGINE_ARITH_EN: when defined, op=11 performs ADD.
REQ-028 SHALL, without MEM_OP_ENGINE_ARITH_EN, treat op=11 as illegal: full FSM sequence, no storage write, result unchanged, carry 0, err=1 with done.

Structure
REQ-029 SHALL place the op encoding, the FSM state type and the default DW/AW constants in package mem_op_engine_pkg.
REQ-030 SHALL implement storage as sub-module mem_op_regfile (2^AW x DW, one write port, one internal read port, one host read port).

Verification
REQ-031 SHALL cover: write mem[1]=0xF0F0_00FF, mem[2]=0x0FF0_FF0F; start op=00 a=1 b=2 c=3 -> done at k+5, result=0x00F0_000F, rd_data(3) matches.
REQ-032 SHALL cover: mem[4]=0xFFFF_FFFF, mem[5]=0x0000_0001, op=11, c=6 -> with macro result=0, carry=1, mem[6]=0; without macro err=1 and mem[6] unchanged.
REQ-033 SHALL cover: start repeated every cycle for 3 ops -> done at k+5, k+10, k+15; intervening starts ignored.
REQ-034 SHALL cover: rst asserted in EXEC -> busy=0 next cycle, no done, all words read 0.
REQ-035 SHALL cover: wr_en to addr 1 while busy -> mem[1] unchanged; wr_en plus start in same cycle -> op uses the new data.
